mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 133 +++++++++++++
 tb/tb_mul_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: radix-2 shift-add multiplier, one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes and the product is negated at
// the end when the operand signs differ, giving a fixed, data-independent
// latency of WIDTH+1 cycles from start to the oDone pulse.
//
// Handshake: iStart is a request that is taken on any edge where oBusy=0
// (IDLE or DONE); while oBusy=1 it is ignored. oDone is a one-cycle valid
// with no backpressure; oResult holds the last completed product until the
// next operation finishes. iAbort only acts while oBusy=1.
module mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic               iAbort,
  input  logic [WIDTH-1:0]   iOperandA,
  input  logic [WIDTH-1:0]   iOperandB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult,
  output logic [1:0]         oState
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier magnitude, shifted right each step
  logic [2*WIDTH-1:0] acc_q, acc_d;       // partial product of magnitudes
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // multiplier bits consumed so far
  logic               neg_q, neg_d;       // product must be negated in FIX
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Magnitude of each operand; the most-negative value maps to 2^(WIDTH-1),
  // which is representable as an unsigned WIDTH-bit number.
  assign mag_a = (iSigned && iOperandA[WIDTH-1]) ? -iOperandA : iOperandA;
  assign mag_b = (iSigned && iOperandB[WIDTH-1]) ? -iOperandB : iOperandB;

  // State register; reset wins over every other input.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: WIDTH RUN edges, one FIX edge, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (iStart) state_d = RUN;
      RUN: begin
        if (iAbort)               state_d = IDLE;
        else if (cnt_q == LAST_BIT) state_d = FIX;
      end
      FIX:     state_d = iAbort ? IDLE : DONE;
      DONE:    state_d = iStart ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    oBusy  = (state_q == RUN) || (state_q == FIX);
    oDone  = (state_q == DONE);
    oState = state_q;
  end

  // Datapath next-state: capture on start, shift-add in RUN, sign fix in FIX.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (iStart) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = iSigned & (iOperandA[WIDTH-1] ^ iOperandB[WIDTH-1]);
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      FIX: begin
        if (!iAbort) result_d = neg_q ? -acc_q : acc_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears the result and all working state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign oResult = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and random bench for mul_sequencer with an expected-result queue.
module tb_mul_sequencer;

  localparam int W = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic           Clock;
  logic           Reset;
  logic           iStart;
  logic           iSigned;
  logic           iAbort;
  logic [W-1:0]   iOperandA;
  logic [W-1:0]   iOperandB;
  logic           oBusy;
  logic           oDone;
  logic [2*W-1:0] oResult;
  logic [1:0]     oState;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res;
  int done_seen;
  logic [W-1:0] ra, rb;
  logic rs;

  mul_sequencer #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iSigned   (iSigned),
    .iAbort    (iAbort),
    .iOperandA (iOperandA),
    .iOperandB (iOperandB),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResult   (oResult),
    .oState    (oState)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference product, computed in 64-bit integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint sa, sb, p;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Driver: present a start for one edge and push the expected product.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic abort, input logic [2*W-1:0] exp);
    iOperandA = a;
    iOperandB = b;
    iSigned   = s;
    iStart    = 1'b1;
    iAbort    = abort;
    exp_q.push_back(exp);
    tick();
    iStart = 1'b0;
    iAbort = 1'b0;
    check("start_state", oState, S_RUN);
    check("start_busy", oBusy, 1'b1);
    check("start_done", oDone, 1'b0);
  endtask

  // Follow an operation to its DONE cycle and score the result there.
  task automatic wait_done(input logic poke);
    logic [2*W-1:0] exp;
    for (int i = 1; i <= W + 1; i++) begin
      if (poke && i == 5) begin
        iStart    = 1'b1;
        iOperandA = ~iOperandA;
        iOperandB = iOperandB + 16'h0101;
        iSigned   = ~iSigned;
      end
      tick();
      iStart = 1'b0;
      if (i <= W) begin
        check("run_busy", oBusy, 1'b1);
        check("run_done", oDone, 1'b0);
        check("run_state", oState, (i < W) ? S_RUN : S_FIX);
        check("run_hold", oResult, last_res);
      end
    end
    check("done_pulse", oDone, 1'b1);
    check("done_busy", oBusy, 1'b0);
    check("done_state", oState, S_DONE);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=%h expected=none", oResult);
    end else begin
      exp = exp_q.pop_front();
      check("result", oResult, exp);
      last_res = exp;
    end
  endtask

  task automatic expect_quiet(input string tag);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oDone) done_seen++;
    end
    check(tag, done_seen, 0);
  endtask

  initial begin
    Reset = 1'b1; iStart = 1'b0; iSigned = 1'b0; iAbort = 1'b0;
    iOperandA = '0; iOperandB = '0; last_res = '0;
    tick(); tick();
    check("rst_state", oState, S_IDLE);
    check("rst_busy", oBusy, 1'b0);
    check("rst_done", oDone, 1'b0);
    check("rst_result", oResult, 32'h0);
    Reset = 1'b0;
    tick();
    check("idle_state", oState, S_IDLE);

    // Unsigned 3 x 5, then one-cycle done pulse
    start_op(16'd3, 16'd5, 1'b0, 1'b0, 32'h0000000F);
    wait_done(1'b0);
    tick();
    check("done_one_cycle", oDone, 1'b0);
    check("back_idle", oState, S_IDLE);

    // Full-range operands, then back-to-back starts from DONE
    start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001);
    wait_done(1'b0);
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'h00000001);
    wait_done(1'b0);
    start_op(16'hFFFD, 16'h0005, 1'b1, 1'b0, 32'hFFFFFFF1);
    wait_done(1'b0);
    start_op(16'h8000, 16'h8000, 1'b1, 1'b0, 32'h40000000);
    wait_done(1'b0);
    start_op(16'h8000, 16'h0001, 1'b1, 1'b0, 32'hFFFF8000);
    wait_done(1'b0);
    tick();

    // Start pulsed mid-RUN with other operands is ignored
    start_op(16'h1234, 16'h00FF, 1'b0, 1'b0, model(16'h1234, 16'h00FF, 1'b0));
    wait_done(1'b1);
    tick();
    check("poke_idle", oState, S_IDLE);

    // Reset in the middle of RUN discards the operation
    start_op(16'h00AB, 16'h0102, 1'b0, 1'b0, model(16'h00AB, 16'h0102, 1'b0));
    repeat (7) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    void'(exp_q.pop_back());
    last_res = '0;
    check("rstrun_state", oState, S_IDLE);
    check("rstrun_result", oResult, 32'h0);
    check("rstrun_busy", oBusy, 1'b0);
    expect_quiet("rstrun_no_done");

    // Abort in the middle of RUN keeps the previous result
    start_op(16'd3, 16'd5, 1'b0, 1'b0, 32'h0000000F);
    wait_done(1'b0);
    tick();
    start_op(16'd7, 16'd9, 1'b0, 1'b0, 32'd63);
    repeat (7) tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    void'(exp_q.pop_back());
    check("abort_state", oState, S_IDLE);
    check("abort_result", oResult, 32'h0000000F);
    check("abort_busy", oBusy, 1'b0);
    expect_quiet("abort_no_done");

    // Reset and start on the same edge: no operation begins
    iOperandA = 16'd9; iOperandB = 16'd9; iSigned = 1'b0;
    iStart = 1'b1; Reset = 1'b1;
    tick();
    iStart = 1'b0; Reset = 1'b0;
    last_res = '0;
    check("rststart_state", oState, S_IDLE);
    check("rststart_result", oResult, 32'h0);
    tick();
    check("rststart_stay", oState, S_IDLE);
    check("rststart_busy", oBusy, 1'b0);

    // Start with abort while idle is accepted
    start_op(16'h0011, 16'h0022, 1'b0, 1'b1, 32'h00000242);
    wait_done(1'b0);
    tick();

    // Random operands against the integer model
    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      rs = 1'($urandom_range(0, 1));
      start_op(ra, rb, rs, 1'b0, model(ra, rb, rs));
      wait_done(1'b0);
      tick();
    end

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
